bus_controller: RTL and testbench
=================================

BUS_CONTROLLER -- requirements
Module: bus_controller

Interface
REQ-001 Parameter BUS_W, default 4, SHALL set the width of the shared register bus and of all data ports.
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 start  input  1  SHALL be the command request, sampled only in IDLE.
REQ-005 op  input  3  SHALL be the opcode, sampled with start.
REQ-006 imm  input  BUS_W  SHALL be the immediate value, sampled with start.
REQ-007 bus  input  BUS_W  SHALL be the resolved shared bus value, read for SWAP capture.
REQ-008 R0in, R1in  output  1 each  SHALL be the register load enables.
REQ-009 R0out, R1out  output  1 each  SHALL be the register tri-state drive enables.
REQ-010 ext_oe  output  1  SHALL enable the external tri-state driving ext_data onto the bus.
REQ-011 ext_data  output  BUS_W  SHALL be the value for the external driver.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 done  output  1  SHALL pulse high for one cycle on command completion.
REQ-014 err  output  1  SHALL pulse high, together with done, for an illegal opcode.

Function
REQ-015 Opcodes SHALL be: 000 NOP; 001 LDI R0 (imm to R0); 010 LDI R1; 011 MOV R0 to R1; 100 MOV R1 to R0; 101 SWAP; 110/111 illegal.
REQ-016 States SHALL be IDLE, EX1, EX2, EX3, DONE; all outputs SHALL be registered and decoded from state plus latched op/imm.
REQ-017 When start=1 in IDLE at cycle N, op/imm SHALL be latched; start while busy=1 SHALL be ignored.
REQ-018 NOP and illegal SHALL go IDLE to DONE (done at N+1) and assert no control line; illegal also sets err.
REQ-019 LDI SHALL assert ext_oe=1, ext_data=imm and the target Rxin in EX1 (N+1); done at N+2.
REQ-020 MOV SHALL assert the source Rxout and the destination Rxin in EX1; done at N+2.
REQ-021 SWAP: EX1 asserts R0out and captures bus into tmp; EX2 asserts R1out and R0in; EX3 asserts ext_oe with ext_data=tmp and R1in; done at N+4.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE; a new start SHALL be accepted at the earliest in the cycle after DONE.
REQ-023 At most one of R0out, R1out and ext_oe SHALL be high in any cycle.
REQ-024 ext_data SHALL be zero whenever ext_oe=0.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, tmp, the latched op/imm and every output to 0, including mid-command; the partial transfer is abandoned.
REQ-026 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-027 With BUS_CTL_SWAP_EN defined, SWAP (101) SHALL behave per REQ-021.
REQ-028 Without BUS_CTL_SWAP_EN, 101 SHALL be illegal (REQ-018), and tmp, EX2 and EX3 SHALL not be built.

Structure
REQ-029 The opcode constants, the state encoding and BUS_W default SHALL live in a shared package, bus_ctl_pkg.
REQ-030 One combinational sub-module, bus_ctl_decode (state and op to the six control lines), SHALL be instantiated.

Verification
REQ-031 LDI R0 with imm=0xA: R0in=1, ext_oe=1, ext_data=0xA at N+1; done=1 at N+2; R0 then reads 0xA.
REQ-032 R0=0x3, R1=0xC, SWAP: control sequence per REQ-021 at N+1..N+3; done at N+4; R0=0xC, R1=0x3.
REQ-033 op=110: done=1 and err=1 at N+1; no control line asserted at any time.
REQ-034 start held high continuously through a MOV: exactly one command executes per IDLE visit; starts seen while busy=1 are ignored.
REQ-035 rst asserted during SWAP EX2: all outputs 0 at once; busy=0; next LDI R1 with imm=0x5 completes normally.
REQ-036 Random legal op stream of 1000 commands: the REQ-023 one-hot-or-zero drive check holds every cycle.

Source files
------------

// File: rtl/bus_ctl_pkg.sv
// bus_ctl_pkg: opcodes, FSM state encoding and default bus width shared by
// the bus controller and its decoder.
// Optional feature macro: BUS_CTL_SWAP_EN (makes opcode 101 a legal SWAP).
package bus_ctl_pkg;

  localparam int BUS_W_DEFAULT = 4;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LDI_R0 = 3'b001;
  localparam logic [2:0] OP_LDI_R1 = 3'b010;
  localparam logic [2:0] OP_MOV_01 = 3'b011;
  localparam logic [2:0] OP_MOV_10 = 3'b100;
  localparam logic [2:0] OP_SWAP   = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EX1  = 3'd1,
    ST_EX2  = 3'd2,
    ST_EX3  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // True for opcodes this build can execute; everything else reports err.
  function automatic logic op_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_NOP, OP_LDI_R0, OP_LDI_R1, OP_MOV_01, OP_MOV_10: legal = 1'b1;
`ifdef BUS_CTL_SWAP_EN
      OP_SWAP: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/bus_ctl_decode.sv
// bus_ctl_decode: pure combinational map from (state, op) to the register
// load/drive enables, the external driver enable and the tmp capture strobe.
// Optional feature macro: BUS_CTL_SWAP_EN (adds the three SWAP steps).
module bus_ctl_decode
  import bus_ctl_pkg::*;
(
  input  logic [2:0] state,
  input  logic [2:0] op,
  output logic       r0_in,
  output logic       r1_in,
  output logic       r0_out,
  output logic       r1_out,
  output logic       ext_oe,
  output logic       tmp_cap
);

  // Decode the control lines for the step the FSM is (about to be) in.
  always_comb begin
    r0_in   = 1'b0;
    r1_in   = 1'b0;
    r0_out  = 1'b0;
    r1_out  = 1'b0;
    ext_oe  = 1'b0;
    tmp_cap = 1'b0;
    case (state)
      ST_EX1: begin
        case (op)
          OP_LDI_R0: begin r0_in  = 1'b1; ext_oe = 1'b1; end
          OP_LDI_R1: begin r1_in  = 1'b1; ext_oe = 1'b1; end
          OP_MOV_01: begin r0_out = 1'b1; r1_in  = 1'b1; end
          OP_MOV_10: begin r1_out = 1'b1; r0_in  = 1'b1; end
`ifdef BUS_CTL_SWAP_EN
          OP_SWAP:   begin r0_out = 1'b1; tmp_cap = 1'b1; end
`endif
          default: ;
        endcase
      end
`ifdef BUS_CTL_SWAP_EN
      ST_EX2: begin
        case (op)
          OP_SWAP: begin r1_out = 1'b1; r0_in = 1'b1; end
          default: ;
        endcase
      end
      ST_EX3: begin
        case (op)
          OP_SWAP: begin ext_oe = 1'b1; r1_in = 1'b1; end
          default: ;
        endcase
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_controller.sv
// bus_controller: sequences two registers and an external driver on a shared
// tri-state bus. All outputs are flops loaded from the decode of the next
// state, so each control line is glitch-free for its whole step.
// Optional feature macro: BUS_CTL_SWAP_EN (SWAP opcode, tmp register, EX2/EX3).
module bus_controller
  import bus_ctl_pkg::*;
#(
  parameter int BUS_W = BUS_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [BUS_W-1:0] imm,
  input  logic [BUS_W-1:0] bus,
  output logic             R0in,
  output logic             R1in,
  output logic             R0out,
  output logic             R1out,
  output logic             ext_oe,
  output logic [BUS_W-1:0] ext_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [BUS_W-1:0] imm_q, imm_d;
  logic [BUS_W-1:0] ext_data_d;
  logic             busy_d, done_d, err_d;

  logic dec_r0_in, dec_r1_in, dec_r0_out, dec_r1_out, dec_ext_oe, dec_tmp_cap;

`ifdef BUS_CTL_SWAP_EN
  logic [BUS_W-1:0] tmp_q, tmp_d;
  logic             tmp_cap_q;
`else
  logic bus_unused;
  assign bus_unused = ^{bus, dec_tmp_cap};
`endif

  // Control lines are decoded from the next state so they register in step.
  bus_ctl_decode u_decode (
    .state   (state_d),
    .op      (op_d),
    .r0_in   (dec_r0_in),
    .r1_in   (dec_r1_in),
    .r0_out  (dec_r0_out),
    .r1_out  (dec_r1_out),
    .ext_oe  (dec_ext_oe),
    .tmp_cap (dec_tmp_cap)
  );

  // Next-state, command latch and next-output computation.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op;
          imm_d = imm;
          if (op_legal(op) && (op != OP_NOP)) begin
            state_d = ST_EX1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EX1: begin
`ifdef BUS_CTL_SWAP_EN
        if (op_q == OP_SWAP) begin
          state_d = ST_EX2;
        end else begin
          state_d = ST_DONE;
        end
`else
        state_d = ST_DONE;
`endif
      end
`ifdef BUS_CTL_SWAP_EN
      ST_EX2:  state_d = ST_EX3;
      ST_EX3:  state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    err_d  = done_d && !op_legal(op_d);

    // The external driver carries imm for LDI and tmp for the SWAP write-back.
    ext_data_d = '0;
    if (dec_ext_oe) begin
`ifdef BUS_CTL_SWAP_EN
      if (state_d == ST_EX3) begin
        ext_data_d = tmp_q;
      end else begin
        ext_data_d = imm_d;
      end
`else
      ext_data_d = imm_d;
`endif
    end else begin
      ext_data_d = '0;
    end

`ifdef BUS_CTL_SWAP_EN
    // tmp samples the bus during the step in which R0 is driving it.
    if (tmp_cap_q) begin
      tmp_d = bus;
    end else begin
      tmp_d = tmp_q;
    end
`endif
  end

  // FSM state, command latch and registered outputs; reset abandons any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= 3'b000;
      imm_q     <= '0;
      R0in      <= 1'b0;
      R1in      <= 1'b0;
      R0out     <= 1'b0;
      R1out     <= 1'b0;
      ext_oe    <= 1'b0;
      ext_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef BUS_CTL_SWAP_EN
      tmp_q     <= '0;
      tmp_cap_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      R0in      <= dec_r0_in;
      R1in      <= dec_r1_in;
      R0out     <= dec_r0_out;
      R1out     <= dec_r1_out;
      ext_oe    <= dec_ext_oe;
      ext_data  <= ext_data_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
`ifdef BUS_CTL_SWAP_EN
      tmp_q     <= tmp_d;
      tmp_cap_q <= dec_tmp_cap;
`endif
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
// tb_bus_controller: drives directed and random commands into bus_controller,
// models the two registers and the resolved bus around it, and checks each
// cycle against a timeline computed from the command rules.
module tb_bus_controller;

`ifdef BUS_CTL_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [3:0] imm;
  logic [3:0] bus;
  logic       R0in, R1in, R0out, R1out, ext_oe;
  logic [3:0] ext_data;
  logic       busy, done, err;

  // Environment registers sitting on the shared bus.
  logic [3:0] env_r0 = 4'h0;
  logic [3:0] env_r1 = 4'h0;

  // Reference register contents.
  logic [3:0] m_r0 = 4'h0;
  logic [3:0] m_r1 = 4'h0;

  int n_cmp = 0;
  int n_bad = 0;

  bus_controller #(.BUS_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .imm      (imm),
    .bus      (bus),
    .R0in     (R0in),
    .R1in     (R1in),
    .R0out    (R0out),
    .R1out    (R1out),
    .ext_oe   (ext_oe),
    .ext_data (ext_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Resolved bus: whichever driver is enabled, otherwise pulled to zero.
  assign bus = R0out ? env_r0 : (R1out ? env_r1 : (ext_oe ? ext_data : 4'h0));

  // Registers load from the bus on the rising edge when enabled.
  always @(posedge clk) begin
    if (R0in) env_r0 <= bus;
    if (R1in) env_r1 <= bus;
  end

  function automatic bit is_illegal(input logic [2:0] o);
    return (o >= 3'd6) || ((o == 3'd5) && !SWAP_EN);
  endfunction

  // Cycles from start sample to done: N+1 for NOP/illegal, N+2 LDI/MOV, N+4 SWAP.
  function automatic int cmd_len(input logic [2:0] o);
    if (is_illegal(o) || (o == 3'd0)) return 1;
    if (o == 3'd5) return 4;
    return 2;
  endfunction

  // Expected {busy,done,err,R0in,R1in,R0out,R1out,ext_oe,ext_data} k cycles after start.
  function automatic logic [11:0] exp_vec(input logic [2:0] o, input int k, input int len,
                                          input logic [3:0] im, input logic [3:0] t, input bit ill);
    logic b, d, e, ri0, ri1, ro0, ro1, oe;
    logic [3:0] dat;
    {b, d, e, ri0, ri1, ro0, ro1, oe} = 8'h00;
    dat = 4'h0;
    if (k > len) begin
      b = 1'b0;
    end else if (k == len) begin
      b = 1'b1; d = 1'b1; e = ill;
    end else begin
      b = 1'b1;
      case (o)
        3'd1: begin ri0 = 1'b1; oe = 1'b1; dat = im; end
        3'd2: begin ri1 = 1'b1; oe = 1'b1; dat = im; end
        3'd3: begin ro0 = 1'b1; ri1 = 1'b1; end
        3'd4: begin ro1 = 1'b1; ri0 = 1'b1; end
        3'd5: begin
          if (k == 1) ro0 = 1'b1;
          else if (k == 2) begin ro1 = 1'b1; ri0 = 1'b1; end
          else begin oe = 1'b1; ri1 = 1'b1; dat = t; end
        end
        default: ;
      endcase
    end
    return {b, d, e, ri0, ri1, ro0, ro1, oe, dat};
  endfunction

  task automatic check_vec(input string tag, input logic [11:0] exp_v);
    logic [11:0] obs;
    logic drive_ok;
    obs = {busy, done, err, R0in, R1in, R0out, R1out, ext_oe, ext_data};
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
    drive_ok = $onehot0({R0out, R1out, ext_oe}) && (ext_oe || (ext_data == 4'h0));
    n_cmp++;
    assert (drive_ok === 1'b1) else begin
      n_bad++;
      $error("FAIL %s_drive observed=%b%b%b/%h expected=onehot0,data0", tag, R0out, R1out, ext_oe, ext_data);
    end
  endtask

  task automatic check_regs(input string tag);
    n_cmp++;
    assert ({env_r0, env_r1} === {m_r0, m_r1}) else begin
      n_bad++;
      $error("FAIL %s_regs observed=%h expected=%h", tag, {env_r0, env_r1}, {m_r0, m_r1});
    end
  endtask

  // Issue one command from a negedge in IDLE; ends at the negedge of the IDLE cycle after DONE.
  task automatic run_cmd(input logic [2:0] o, input logic [3:0] im, input bit hold);
    int len;
    bit ill;
    logic [3:0] t;
    ill = is_illegal(o);
    len = cmd_len(o);
    t = m_r0;
    start = 1'b1;
    op = o;
    imm = im;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      check_vec($sformatf("op%0d_k%0d", o, k), exp_vec(o, k, len, im, t, ill));
    end
    case (o)
      3'd1: m_r0 = im;
      3'd2: m_r1 = im;
      3'd3: m_r1 = m_r0;
      3'd4: m_r0 = m_r1;
      3'd5: if (!ill) begin m_r0 = m_r1; m_r1 = t; end
      default: ;
    endcase
    check_regs($sformatf("op%0d", o));
  endtask

  initial begin
    int len5;
    logic [3:0] t5;
    rst = 1'b1;
    start = 1'b0;
    op = 3'd0;
    imm = 4'h0;
    repeat (3) @(negedge clk);
    check_vec("reset", 12'h000);
    rst = 1'b0;

    // LDI R0 0xA straight after reset release.
    run_cmd(3'd1, 4'hA, 1'b0);
    run_cmd(3'd0, 4'h7, 1'b0);

    // SWAP with R0=3, R1=C.
    run_cmd(3'd1, 4'h3, 1'b0);
    run_cmd(3'd2, 4'hC, 1'b0);
    run_cmd(3'd5, 4'h0, 1'b0);

    // Illegal opcodes.
    run_cmd(3'd6, 4'hF, 1'b0);
    run_cmd(3'd7, 4'h1, 1'b0);

    // Moves in both directions.
    run_cmd(3'd1, 4'h9, 1'b0);
    run_cmd(3'd3, 4'h0, 1'b0);
    run_cmd(3'd2, 4'h4, 1'b0);
    run_cmd(3'd4, 4'h0, 1'b0);

    // start held high across MOV commands: one command per IDLE visit.
    run_cmd(3'd1, 4'h6, 1'b0);
    run_cmd(3'd3, 4'h0, 1'b1);
    run_cmd(3'd3, 4'h0, 1'b1);
    run_cmd(3'd4, 4'h0, 1'b0);

    // Reset during SWAP step 2, then LDI R1 0x5.
    run_cmd(3'd1, 4'h3, 1'b0);
    run_cmd(3'd2, 4'hC, 1'b0);
    len5 = cmd_len(3'd5);
    t5 = m_r0;
    start = 1'b1;
    op = 3'd5;
    imm = 4'h0;
    @(negedge clk);
    start = 1'b0;
    check_vec("rsw_k1", exp_vec(3'd5, 1, len5, 4'h0, t5, is_illegal(3'd5)));
    @(negedge clk);
    check_vec("rsw_k2", exp_vec(3'd5, 2, len5, 4'h0, t5, is_illegal(3'd5)));
    #1 rst = 1'b1;
    #1 check_vec("rst_mid", 12'h000);
    @(negedge clk);
    check_vec("rst_hold", 12'h000);
    rst = 1'b0;
    run_cmd(3'd2, 4'h5, 1'b0);

    // Random command stream.
    for (int i = 0; i < 1000; i++) begin
      run_cmd(3'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
